// File: rtl/seven_seg_pkg.sv
// Shared definitions for the seven-segment display paths: glyph encodings and
// the capture frame states.
package seven_seg_pkg;

    localparam int SEG_W    = 7;
    localparam int NIBBLE_W = 4;

    // Segment order [g f e d c b a], 1 = lit
    localparam logic [SEG_W-1:0] GLYPH_0 = 7'h3F;
    localparam logic [SEG_W-1:0] GLYPH_1 = 7'h06;
    localparam logic [SEG_W-1:0] GLYPH_2 = 7'h5B;
    localparam logic [SEG_W-1:0] GLYPH_3 = 7'h4F;
    localparam logic [SEG_W-1:0] GLYPH_4 = 7'h66;
    localparam logic [SEG_W-1:0] GLYPH_5 = 7'h6D;
    localparam logic [SEG_W-1:0] GLYPH_6 = 7'h7D;
    localparam logic [SEG_W-1:0] GLYPH_7 = 7'h07;
    localparam logic [SEG_W-1:0] GLYPH_8 = 7'h7F;
    localparam logic [SEG_W-1:0] GLYPH_9 = 7'h6F;
    localparam logic [SEG_W-1:0] GLYPH_A = 7'h77;
    localparam logic [SEG_W-1:0] GLYPH_B = 7'h7C;
    localparam logic [SEG_W-1:0] GLYPH_C = 7'h39;
    localparam logic [SEG_W-1:0] GLYPH_D = 7'h5E;
    localparam logic [SEG_W-1:0] GLYPH_E = 7'h79;
    localparam logic [SEG_W-1:0] GLYPH_F = 7'h71;

    typedef enum logic {
        S_COLLECT,
        S_REPORT
    } frame_state_t;

endpackage

// File: rtl/seven_seg_glyph_lookup.sv
// Reverse glyph decoder: segment pattern to hex nibble, with a hit flag for
// patterns that are not one of the sixteen legal glyphs.
module seven_seg_glyph_lookup
    import seven_seg_pkg::*;
(
    input  logic [SEG_W-1:0]    i_seg,
    output logic                o_hit,
    output logic [NIBBLE_W-1:0] o_nibble
);

    always_comb begin
        o_hit    = 1'b1;
        o_nibble = '0;
        case (i_seg)
            GLYPH_0: o_nibble = 4'h0;
            GLYPH_1: o_nibble = 4'h1;
            GLYPH_2: o_nibble = 4'h2;
            GLYPH_3: o_nibble = 4'h3;
            GLYPH_4: o_nibble = 4'h4;
            GLYPH_5: o_nibble = 4'h5;
            GLYPH_6: o_nibble = 4'h6;
            GLYPH_7: o_nibble = 4'h7;
            GLYPH_8: o_nibble = 4'h8;
            GLYPH_9: o_nibble = 4'h9;
            GLYPH_A: o_nibble = 4'hA;
            GLYPH_B: o_nibble = 4'hB;
            GLYPH_C: o_nibble = 4'hC;
            GLYPH_D: o_nibble = 4'hD;
            GLYPH_E: o_nibble = 4'hE;
            GLYPH_F: o_nibble = 4'hF;
            default: o_hit    = 1'b0;
        endcase
    end

endmodule

// File: rtl/seven_seg_capture.sv
// Multiplexed seven-segment bus receiver: debounces each digit, decodes the
// glyph and reports one assembled word (or an error mask) per complete frame.
//
// state     | meaning
// S_COLLECT | gathering digit commits until every digit has been captured
// S_REPORT  | one cycle: publish word or error mask, then clear the frame
module seven_seg_capture
    import seven_seg_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int STABLE_CNT = 3,
    parameter int CNT_W      = 2
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [SEG_W-1:0]          seg_in,
    input  logic [NUM_DIGITS-1:0]     an_in,
    output logic [4*NUM_DIGITS-1:0]   value_out,
    output logic                      valid_out,
    output logic                      frame_err,
    output logic [NUM_DIGITS-1:0]     err_mask,
    output logic                      mux_err
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CNT);

    frame_state_t                r_state;
    frame_state_t                w_state_next;
    logic [SEG_W-1:0]            r_seg;
    logic [NUM_DIGITS-1:0]       r_an;
    logic [CNT_W-1:0]            r_cnt;
    logic [CNT_W-1:0]            w_cnt_next;
    logic [4*NUM_DIGITS-1:0]     r_slots;
    logic [NUM_DIGITS-1:0]       r_cap;
    logic [NUM_DIGITS-1:0]       r_err;
    logic [NUM_DIGITS-1:0]       w_cap_next;
    logic [NUM_DIGITS-1:0]       w_err_next;
    logic                        w_blank;
    logic                        w_multi;
    logic                        w_same;
    logic                        w_commit;
    logic                        w_hit;
    logic [NIBBLE_W-1:0]         w_nibble;
    logic                        w_report_ok;
    logic                        w_report_bad;

    seven_seg_glyph_lookup u_lookup (
        .i_seg    (seg_in),
        .o_hit    (w_hit),
        .o_nibble (w_nibble)
    );

    // r_seg/r_an hold the previous sample; the incoming sample is judged against it
    assign w_blank  = (an_in == '0);
    assign w_multi  = ((an_in & (an_in - NUM_DIGITS'(1))) != '0);
    assign w_same   = (seg_in == r_seg) && (an_in == r_an);
    assign w_commit = !w_blank && !w_multi && (w_cnt_next == CNT_MAX)
                      && (!w_same || (r_cnt != CNT_MAX));

    always_comb begin
        w_cnt_next = r_cnt;
        if (w_blank || w_multi) begin
            w_cnt_next = '0;
        end else if (!w_same) begin
            w_cnt_next = CNT_W'(1);
        end else if (r_cnt != CNT_MAX) begin
            w_cnt_next = r_cnt + CNT_W'(1);
        end
    end

    // A commit arriving during REPORT lands on the freshly cleared masks
    always_comb begin
        w_cap_next = (r_state == S_REPORT) ? '0 : r_cap;
        w_err_next = (r_state == S_REPORT) ? '0 : r_err;
        if (w_commit) begin
            w_cap_next = w_cap_next | an_in;
            if (w_hit) begin
                w_err_next = w_err_next & ~an_in;
            end else begin
                w_err_next = w_err_next | an_in;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_COLLECT;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_COLLECT: if (w_commit && (&w_cap_next)) w_state_next = S_REPORT;
            S_REPORT:  w_state_next = S_COLLECT;
            default:   w_state_next = S_COLLECT;
        endcase
    end

    always_comb begin
        w_report_ok  = 1'b0;
        w_report_bad = 1'b0;
        if (r_state == S_REPORT) begin
            w_report_ok  = (r_err == '0);
            w_report_bad = (r_err != '0);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_seg     <= '0;
            r_an      <= '0;
            r_cnt     <= '0;
            r_slots   <= '0;
            r_cap     <= '0;
            r_err     <= '0;
            value_out <= '0;
            valid_out <= 1'b0;
            frame_err <= 1'b0;
            err_mask  <= '0;
            mux_err   <= 1'b0;
        end else begin
            r_seg     <= seg_in;
            r_an      <= an_in;
            r_cnt     <= w_cnt_next;
            r_cap     <= w_cap_next;
            r_err     <= w_err_next;
            valid_out <= w_report_ok;
            frame_err <= w_report_bad;
            mux_err   <= w_multi;
            for (int i = 0; i < NUM_DIGITS; i++) begin
                if (w_commit && an_in[i] && w_hit) begin
                    r_slots[4*i +: 4] <= w_nibble;
                end
            end
            if (r_state == S_REPORT) begin
                err_mask <= r_err;
            end
            if (w_report_ok) begin
                value_out <= r_slots;
            end
        end
    end

endmodule

// File: tb/tb_seven_seg_capture.sv
// Self-checking bench for seven_seg_capture: directed scan table, hand-written
// latency/reset sequences and a randomized run against a frame-level model.
module tb_seven_seg_capture;

    localparam int ND = 4;
    localparam int SC = 3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [6:0]  seg_in = '0;
    logic [3:0]  an_in = '0;
    logic [15:0] value_out;
    logic        valid_out;
    logic        frame_err;
    logic [3:0]  err_mask;
    logic        mux_err;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    seven_seg_capture #(.NUM_DIGITS(ND), .STABLE_CNT(SC), .CNT_W(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .seg_in    (seg_in),
        .an_in     (an_in),
        .value_out (value_out),
        .valid_out (valid_out),
        .frame_err (frame_err),
        .err_mask  (err_mask),
        .mux_err   (mux_err)
    );

    logic [6:0] glyphs [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    // Frame-level reference: run length of identical one-hot samples, digit
    // table, captured/error sets and a pending-report flag.
    logic [3:0]  m_slot [4];
    logic [3:0]  m_cap, m_err, m_errmask;
    logic [15:0] m_value;
    logic        m_valid, m_ferr, m_mux;
    bit          m_pend;
    logic [10:0] m_prev;
    int          m_run;

    int n_valid, n_ferr, n_mux;

    function automatic int decode(input logic [6:0] s);
        for (int k = 0; k < 16; k++) if (glyphs[k] == s) return k;
        return -1;
    endfunction

    task automatic model_step(input logic rst, input logic [3:0] an, input logic [6:0] sg);
        bit was_pend;
        int ones;
        int g;
        if (!rst) begin
            for (int k = 0; k < 4; k++) m_slot[k] = '0;
            m_cap = '0; m_err = '0; m_errmask = '0; m_value = '0;
            m_valid = 0; m_ferr = 0; m_mux = 0; m_pend = 0; m_prev = '0; m_run = 0;
            return;
        end
        was_pend = m_pend;
        ones = $countones(an);
        m_valid = m_pend && (m_err == 0);
        m_ferr  = m_pend && (m_err != 0);
        if (m_pend) begin
            m_errmask = m_err;
            if (m_err == 0) m_value = {m_slot[3], m_slot[2], m_slot[1], m_slot[0]};
            m_cap = '0;
            m_err = '0;
            m_pend = 0;
        end
        m_mux = (ones > 1);
        if (ones != 1) m_run = 0;
        else if ({sg, an} == m_prev && m_run > 0) m_run++;
        else m_run = 1;
        m_prev = {sg, an};
        if (m_run == SC) begin
            g = decode(sg);
            for (int k = 0; k < 4; k++) begin
                if (an[k]) begin
                    m_cap[k] = 1'b1;
                    if (g >= 0) begin
                        m_slot[k] = 4'(g);
                        m_err[k] = 1'b0;
                    end else begin
                        m_err[k] = 1'b1;
                    end
                end
            end
            if (!was_pend && m_cap == 4'hF) m_pend = 1;
        end
    endtask

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic tick(input logic [3:0] an, input logic [6:0] sg);
        an_in = an;
        seg_in = sg;
        @(posedge clk);
        model_step(rst_n, an, sg);
        @(negedge clk);
        check("cycle", 32'({value_out, valid_out, frame_err, err_mask, mux_err}),
                       32'({m_value, m_valid, m_ferr, m_errmask, m_mux}));
        n_valid += int'(valid_out);
        n_ferr  += int'(frame_err);
        n_mux   += int'(mux_err);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick(4'h0, 7'h00);
        rst_n = 1'b1;
    endtask

    task automatic hold(input logic [3:0] an, input logic [6:0] sg, input int n);
        for (int k = 0; k < n; k++) tick(an, sg);
    endtask

    typedef struct {
        int         tid;
        logic [3:0] an;
        logic [6:0] sg;
        int         hold;
    } vec_t;

    typedef struct {
        bit          do_rst;
        logic [15:0] val;
        int          nv;
        int          nf;
        int          nm;
        logic [3:0]  mask;
    } exp_t;

    vec_t vecs [25];
    exp_t exps [5];
    logic [3:0] multi_pat [8] = '{4'h3, 4'h5, 4'h6, 4'h9, 4'hA, 4'hC, 4'h7, 4'hF};

    initial begin
        vecs = '{
            '{0, 4'h1, 7'h06, 3}, '{0, 4'h2, 7'h5B, 3}, '{0, 4'h4, 7'h4F, 3}, '{0, 4'h8, 7'h66, 3},
            '{0, 4'h0, 7'h00, 2},
            '{1, 4'h1, 7'h3F, 3}, '{1, 4'h2, 7'h00, 3}, '{1, 4'h4, 7'h4F, 3}, '{1, 4'h8, 7'h66, 3},
            '{1, 4'h0, 7'h00, 2},
            '{2, 4'h6, 7'h5B, 3}, '{2, 4'h0, 7'h00, 2},
            '{3, 4'h1, 7'h06, 3}, '{3, 4'h2, 7'h5B, 3}, '{3, 4'h4, 7'h4F, 2}, '{3, 4'h0, 7'h00, 1},
            '{3, 4'h8, 7'h66, 3}, '{3, 4'h4, 7'h7D, 3}, '{3, 4'h0, 7'h00, 2},
            '{4, 4'h1, 7'h7F, 3}, '{4, 4'h1, 7'h71, 3}, '{4, 4'h2, 7'h06, 3}, '{4, 4'h4, 7'h06, 3},
            '{4, 4'h8, 7'h06, 3}, '{4, 4'h0, 7'h00, 2}
        };
        exps = '{
            '{1'b1, 16'h4321, 1, 0, 0, 4'b0000},
            '{1'b0, 16'h4321, 0, 1, 0, 4'b0010},
            '{1'b0, 16'h4321, 0, 0, 3, 4'b0010},
            '{1'b1, 16'h4621, 1, 0, 0, 4'b0000},
            '{1'b1, 16'h111F, 1, 0, 0, 4'b0000}
        };

        do_reset();
        check("reset_value", 32'(value_out), 32'h0);
        check("reset_flags", 32'({valid_out, frame_err, err_mask, mux_err}), 32'h0);

        for (int t = 0; t < 5; t++) begin
            if (exps[t].do_rst) do_reset();
            n_valid = 0; n_ferr = 0; n_mux = 0;
            for (int v = 0; v < 25; v++)
                if (vecs[v].tid == t) hold(vecs[v].an, vecs[v].sg, vecs[v].hold);
            check($sformatf("t%0d_value", t), 32'(value_out), 32'(exps[t].val));
            check($sformatf("t%0d_nvalid", t), 32'(n_valid), 32'(exps[t].nv));
            check($sformatf("t%0d_nferr", t), 32'(n_ferr), 32'(exps[t].nf));
            check($sformatf("t%0d_nmux", t), 32'(n_mux), 32'(exps[t].nm));
            check($sformatf("t%0d_mask", t), 32'(err_mask), 32'(exps[t].mask));
        end

        // Reset after three digits: partial frame discarded, word back to zero
        hold(4'h1, 7'h77, 3);
        hold(4'h2, 7'h7C, 3);
        hold(4'h4, 7'h39, 3);
        check("pre_reset_value", 32'(value_out), 32'h111F);
        do_reset();
        check("mid_reset_value", 32'(value_out), 32'h0);
        n_valid = 0;
        hold(4'h1, 7'h77, 3);
        hold(4'h2, 7'h7C, 3);
        hold(4'h4, 7'h39, 3);
        for (int e = 0; e < 5; e++) begin
            tick(4'h8, 7'h5E);
            check($sformatf("latency_edge%0d", e), 32'(valid_out), (e == 3) ? 32'h1 : 32'h0);
        end
        check("t5_value", 32'(value_out), 32'hDCBA);
        check("t5_nvalid", 32'(n_valid), 32'h1);

        for (int c = 0; c < 600; ) begin
            int kind;
            int n;
            logic [3:0] an;
            logic [6:0] sg;
            kind = $urandom_range(0, 19);
            n = $urandom_range(1, 5);
            sg = ($urandom_range(0, 4) == 0) ? 7'($urandom) : glyphs[$urandom_range(0, 15)];
            if (kind == 0) begin
                do_reset();
                c++;
                continue;
            end else if (kind <= 2) an = 4'h0;
            else if (kind == 3) an = multi_pat[$urandom_range(0, 7)];
            else an = 4'(1 << $urandom_range(0, 3));
            hold(an, sg, n);
            c += n;
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
